// File: rtl/alu_sequencer.sv
// Command-side sequencer for a registered ALU: single-op issue/capture,
// shift-add multiply on the same ALU, and a valid/ready result port.
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic             instr_zx,
  input  logic             instr_zy,
  input  logic             instr_neg,
  input  logic [2:0]       instr_cond,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zero_x,
  output logic             alu_zero_y,
  output logic             alu_negate,
  output logic [1:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_is_negative,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_z,
  output logic             res_n,
  output logic             res_err,
  output logic             cond_true
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]       r_op;
  logic             r_zx;
  logic             r_zy;
  logic             r_neg;
  logic [2:0]       r_cond;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [IW-1:0]    r_i;

  logic [WIDTH-1:0] r_data;
  logic             r_z;
  logic             r_n;
  logic             r_err;
  logic             r_ct;

  logic w_accept;
  logic w_illegal;
  logic w_mul;
  logic w_cmp;
  logic w_last;
  logic w_z;
  logic w_n;
  logic w_hit;
  logic w_capture;

  assign w_accept  = instr_valid && (r_state == S_IDLE);
  assign w_illegal = (instr_op[2:1] == 2'b11);
  assign w_mul     = (r_op == 3'd4);
  assign w_cmp     = (r_op == 3'd5);
  assign w_last    = (r_i == IW'(WIDTH - 1));
  assign w_z       = (alu_result == '0);
  assign w_n       = alu_is_negative;
  assign w_capture = (r_state == S_WAIT) && (!w_mul || w_last);

  assign instr_ready = (r_state == S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign res_data    = r_data;
  assign res_z       = r_z;
  assign res_n       = r_n;
  assign res_err     = r_err;
  assign cond_true   = r_ct;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_next = w_illegal ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        w_next = (w_mul && !w_last) ? S_ISSUE : S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ISSUE and WAIT drive identical controls so the ALU sees a stable command
  always_comb begin
    alu_x      = '0;
    alu_y      = '0;
    alu_zero_x = 1'b1;
    alu_zero_y = 1'b1;
    alu_negate = 1'b0;
    alu_opcode = 2'd0;
    if (r_state == S_ISSUE || r_state == S_WAIT) begin
      if (w_mul) begin
        alu_x      = r_acc;
        alu_y      = r_a << r_i;
        alu_zero_x = 1'b0;
        alu_zero_y = ~r_b[r_i];
        alu_negate = 1'b0;
        alu_opcode = 2'd2;
      end else begin
        alu_x      = r_a;
        alu_y      = r_b;
        alu_zero_x = r_zx;
        alu_zero_y = r_zy;
        alu_negate = r_neg;
        alu_opcode = w_cmp ? 2'd3 : r_op[1:0];
      end
    end
  end

  always_comb begin
    w_hit = 1'b0;
    unique case (r_cond)
      3'd0:    w_hit = 1'b0;
      3'd1:    w_hit = 1'b1;
      3'd2:    w_hit = w_z;
      3'd3:    w_hit = !w_z;
      3'd4:    w_hit = w_n;
      3'd5:    w_hit = !w_n;
      3'd6:    w_hit = w_n || w_z;
      default: w_hit = !w_n && !w_z;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_zx   <= 1'b0;
      r_zy   <= 1'b0;
      r_neg  <= 1'b0;
      r_cond <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_i    <= '0;
      r_data <= '0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
      r_err  <= 1'b0;
      r_ct   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= instr_op;
        r_zx   <= instr_zx;
        r_zy   <= instr_zy;
        r_neg  <= instr_neg;
        r_cond <= instr_cond;
        r_a    <= operand_a;
        r_b    <= operand_b;
        r_acc  <= '0;
        r_i    <= '0;
        if (w_illegal) begin
          r_data <= '0;
          r_z    <= 1'b1;
          r_n    <= 1'b0;
          r_err  <= 1'b1;
          r_ct   <= 1'b0;
        end
      end
      if (r_state == S_WAIT && w_mul) begin
        r_acc <= alu_result;
        if (!w_last) begin
          r_i <= r_i + 1'b1;
        end
      end
      // final MUL acc equals alu_result here, so flags come from it
      if (w_capture) begin
        r_data <= w_cmp ? r_a : alu_result;
        r_z    <= w_z;
        r_n    <= w_n;
        r_err  <= 1'b0;
        r_ct   <= w_hit;
      end
    end
  end

endmodule
